// File: rtl/mux_4to1_dec_buf_if.sv
// rtl/mux_4to1_dec_buf_if.sv - lane/select bundle for the registered 4:1 decoder-buffer selector
interface mux_4to1_dec_buf_if #(
    parameter int WIDTH = 1
);
    logic [4*WIDTH-1:0] in;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   y;
    logic [3:0]         sel_onehot;

    modport master (
        output in,
        output sel,
        input  y,
        input  sel_onehot
    );

    modport slave (
        input  in,
        input  sel,
        output y,
        output sel_onehot
    );
endinterface

// File: rtl/mux_4to1_dec_buf.sv
// rtl/mux_4to1_dec_buf.sv - registered 4:1 selector: one-hot decoder, AND-gated lane buffers, OR combine
module mux_4to1_dec_buf #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_4to1_dec_buf_if.slave     bus
);

    logic [3:0]       sel_onehot_d;
    logic [3:0]       sel_onehot_q;
    logic [WIDTH-1:0] lane_buf [4];
    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] y_q;

    always_comb begin
        sel_onehot_d = '0;
        for (int k = 0; k < 4; k++) begin
            sel_onehot_d[k] = (bus.sel == 2'(k));
        end
    end

    // Buffers are AND gates, so a deselected lane contributes zeros to the OR bus.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_buf[k] = {WIDTH{sel_onehot_d[k]}} & bus.in[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        mux_d = '0;
        for (int k = 0; k < 4; k++) begin
            mux_d = mux_d | lane_buf[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q          <= '0;
            sel_onehot_q <= 4'b0000;
        end else begin
            y_q          <= mux_d;
            sel_onehot_q <= sel_onehot_d;
        end
    end

    assign bus.y          = y_q;
    assign bus.sel_onehot = sel_onehot_q;

endmodule

// File: tb/tb_mux_4to1_dec_buf.sv
// tb/tb_mux_4to1_dec_buf.sv - scoreboard bench for mux_4to1_dec_buf at WIDTH 1 and 8
module tb_mux_4to1_dec_buf;

    logic clk;
    logic rst;

    mux_4to1_dec_buf_if #(.WIDTH(1)) bus1 ();
    mux_4to1_dec_buf_if #(.WIDTH(8)) bus8 ();

    mux_4to1_dec_buf #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mux_4to1_dec_buf #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       y1;
        logic [3:0] oh;
        logic [7:0] y8;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic pick1(input logic [3:0] v, input logic [1:0] s);
        return v[s];
    endfunction

    function automatic logic [7:0] pick8(input logic [31:0] v, input logic [1:0] s);
        return v[s*8 +: 8];
    endfunction

    task automatic check_y1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s y1 observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_oh(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s sel_onehot observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_y8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s y8 observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic [1:0] s,
                        input logic [3:0] i1, input logic [31:0] i8);
        exp_t e;
        rst      = r;
        bus1.sel = s;
        bus8.sel = s;
        bus1.in  = i1;
        bus8.in  = i8;
        if (r) begin
            e = '0;
        end else begin
            e.y1 = pick1(i1, s);
            e.oh = 4'b0001 << s;
            e.y8 = pick8(i8, s);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            check_y1(tag, bus1.y, e.y1);
            check_oh(tag, bus1.sel_onehot, e.oh);
            check_y8(tag, bus8.y, e.y8);
            check_oh({tag, "_w8"}, bus8.sel_onehot, e.oh);
        end
    endtask

    localparam logic [31:0] WIDE = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

    initial begin
        rst      = 1'b1;
        bus1.in  = 4'b1111;
        bus1.sel = 2'b11;
        bus8.in  = 32'hFFFF_FFFF;
        bus8.sel = 2'b11;

        step("reset0", 1'b1, 2'b11, 4'b1111, 32'hFFFF_FFFF);
        step("reset1", 1'b1, 2'b11, 4'b1111, 32'hFFFF_FFFF);

        step("sweep0", 1'b0, 2'b00, 4'b1000, WIDE);
        step("sweep1", 1'b0, 2'b01, 4'b1000, WIDE);
        step("sweep2", 1'b0, 2'b10, 4'b1000, WIDE);
        step("sweep3", 1'b0, 2'b11, 4'b1000, WIDE);

        step("iso_off", 1'b0, 2'b11, 4'b0111, 32'h00FF_FFFF);
        step("iso_on",  1'b0, 2'b11, 4'b1000, 32'h8000_0000);

        step("lat_n", 1'b0, 2'b00, 4'b0001, 32'h0000_0055);
        bus1.sel = 2'b01;
        bus8.sel = 2'b01;
        bus8.in  = 32'h0000_AA00;
        #2;
        check_y1("lat_hold", bus1.y, 1'b1);
        check_y8("lat_hold", bus8.y, 8'h55);
        step("lat_n1", 1'b0, 2'b01, 4'b0001, 32'h0000_AA00);

        step("mid0",   1'b0, 2'b00, 4'b1010, WIDE);
        step("mid1",   1'b0, 2'b01, 4'b1010, WIDE);
        step("midrst", 1'b1, 2'b00, 4'b1010, WIDE);
        step("mid2",   1'b0, 2'b01, 4'b1010, WIDE);
        step("mid3",   1'b0, 2'b00, 4'b1010, WIDE);

        step("wide0", 1'b0, 2'b00, 4'b0101, WIDE);
        step("wide1", 1'b0, 2'b01, 4'b0101, WIDE);
        step("wide2", 1'b0, 2'b10, 4'b0101, WIDE);
        step("wide3", 1'b0, 2'b11, 4'b0101, WIDE);

        for (int n = 0; n < 24; n++) begin
            step("rand", ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4to1_dec_buf.md
# mux_4to1_dec_buf

Registered 4:1 selector built from a 2-to-4 one-hot decoder driving four gated lane buffers. The lane outputs are OR-combined and the result is captured in an output register. It sits in datapath steering logic wherever one of four equal-width sources must feed a single registered sink, and it also exports the registered one-hot select for downstream bookkeeping.

## Interface
- WIDTH, default 1, bit width of each input lane and of y.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- in  input  4*WIDTH  four packed lanes; lane k = in[k*WIDTH +: WIDTH] (lane 0 in the LSBs).
- sel  input  2  lane select, unsigned binary 0..3.
- y  output  WIDTH  registered selected lane.
- sel_onehot  output  4  registered decoder output; bit k set when lane k was selected.

## Operation
- Decoder: combinational, dec[k] = (sel == k). It is always exactly one-hot for any known sel value.
- Lane buffers: buf_k = {WIDTH{dec[k]}} & lane k. Buffers are modelled as AND gating, not as tri-states.
  - No Z values are allowed on any internal or external net.
  - Only one buffer is enabled at a time, so the combined bus is never driven by more than one source.
- Combine: mux_d = buf_0 | buf_1 | buf_2 | buf_3, a bitwise OR across the four lanes.
- Output register, on every rising clk:
  - rst = 1: y <= 0 and sel_onehot <= 4'b0000.
  - rst = 0: y <= mux_d and sel_onehot <= dec.
- There is no enable and no hold state. The register reloads every cycle while out of reset.
- Widths:
  - No arithmetic is involved.
  - y is exactly WIDTH bits.
  - Unselected lanes never affect y, whatever their values.
- sel is required to be known (0/1) whenever rst = 0. Behaviour with X/Z on sel is not specified and is not checked.

## Timing
- Latency is 1 cycle: y and sel_onehot reflect the in and sel values sampled at rising edge N, and are visible right after edge N.
- No combinational path from any input to any output.
- Reset:
  - Synchronous, and takes effect at the first rising edge with rst = 1.
  - Outputs are 0 from that edge onward.
  - The input data present at that edge is discarded.
- Reset release:
  - The first edge with rst = 0 loads the current in/sel.
  - No extra warm-up cycle.
- rst asserted mid-stream: outputs go to 0 at the next edge, even when in and sel keep changing. Normal tracking resumes one edge after deassertion.
- sel or in changing every cycle: each edge captures the values present at that edge; no glitch can reach y.
- Power-up before the first reset: outputs are undefined until the first reset edge.

## Test plan
- Reset check: rst = 1 for 2 edges with in = 4'b1111, sel = 2'b11, WIDTH = 1 -> y = 0 and sel_onehot = 4'b0000 after each edge.
- Lane sweep: in = 4'b1000, sel = 00, 01, 10, 11 on successive edges -> y = 0, 0, 0, 1 and sel_onehot = 0001, 0010, 0100, 1000, each one edge later.
- Lane isolation: in = 4'b0111, sel = 11 -> y = 0; then in = 4'b1000, sel = 11 -> y = 1. Proves unselected lanes are ignored.
- Latency: in = 4'b0001, sel = 00 at edge N, then sel = 01 at edge N+1 -> y = 1 after N and y = 0 after N+1. No change is visible between edges.
- Mid-stream reset: toggle sel every cycle with in = 4'b1010, and assert rst for one edge -> y = 0 and sel_onehot = 0 for that edge only. On the following edge y equals in[sel].
- Wide lanes, WIDTH = 8: in = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, sel = 0..3 -> y = AA, BB, CC, DD, each one edge later.
